// File: rtl/sdram_pkg.sv
// Shared SDRAM controller constants: bus widths, default burst length and
// the byte-select encoding used by the 16-to-8 read-return FIFO.
package sdram_pkg;

  localparam int unsigned SDRAM_DQ_W    = 16;
  localparam int unsigned USER_DATA_W   = 8;
  localparam int unsigned BURST_LEN_DEF = 8;

  // byte_sel encoding: which half of the head word is delivered next
  localparam logic LO_BYTE = 1'b0;
  localparam logic HI_BYTE = 1'b1;

  typedef logic [SDRAM_DQ_W-1:0]  dq_word_t;
  typedef logic [USER_DATA_W-1:0] user_byte_t;

endpackage

// File: rtl/rfifo_sync_16to8_if.sv
// Handshake/data bundle for the read-return FIFO. The master modport is the
// environment (SDRAM read-capture stage plus user reader); the slave modport
// is the FIFO itself. Optional macro RFIFO_ERR_FLAGS_EN adds sticky
// overflow/underflow flags.
interface rfifo_sync_16to8_if
  import sdram_pkg::*;
#(
  parameter int unsigned AW = 9
) ();

  logic          fifo_wr_en;
  dq_word_t      fifo_wr_data;
  logic          fifo_full;
  logic          fifo_rd_en;
  user_byte_t    fifo_rd_data;
  logic          fifo_rd_valid;
  logic          fifo_empty;
  logic [AW+1:0] fifo_byte_cnt;
  logic          rfifo_burst_ready;
`ifdef RFIFO_ERR_FLAGS_EN
  logic          fifo_wr_err;
  logic          fifo_rd_err;
`endif

  modport master (
    output fifo_wr_en,
    output fifo_wr_data,
    output fifo_rd_en,
    input  fifo_full,
    input  fifo_rd_data,
    input  fifo_rd_valid,
    input  fifo_empty,
    input  fifo_byte_cnt,
`ifdef RFIFO_ERR_FLAGS_EN
    input  fifo_wr_err,
    input  fifo_rd_err,
`endif
    input  rfifo_burst_ready
  );

  modport slave (
    input  fifo_wr_en,
    input  fifo_wr_data,
    input  fifo_rd_en,
    output fifo_full,
    output fifo_rd_data,
    output fifo_rd_valid,
    output fifo_empty,
    output fifo_byte_cnt,
`ifdef RFIFO_ERR_FLAGS_EN
    output fifo_wr_err,
    output fifo_rd_err,
`endif
    output rfifo_burst_ready
  );

endinterface

// File: rtl/rfifo_ram_sync.sv
// DEPTH x DW simple dual-port RAM: one synchronous write port and one
// registered read port. The read register only loads on rd_en_i so it holds
// its last word otherwise; it resets to zero so the FIFO output starts at 0.
module rfifo_ram_sync #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q, rd_data_d;

  // Write port: storage is never cleared, reset only discards pointers upstream
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register next-state: load on read, otherwise hold
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = mem[rd_addr_i];
    end
  end

  // Read register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rfifo_sync_16to8.sv
// Single-clock read-return FIFO: accepts 16-bit SDRAM words and hands them to
// the user side as bytes, low byte first. Word-level full, byte-level empty,
// byte fill count and a burst-space flag are decoded from registers.
// Optional macro RFIFO_ERR_FLAGS_EN adds sticky fifo_wr_err / fifo_rd_err.
module rfifo_sync_16to8
  import sdram_pkg::*;
#(
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned AW        = 9,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input logic               clk,
  input logic               rst,
  rfifo_sync_16to8_if.slave fifo_if
);

  localparam logic [AW:0] DepthW = DEPTH[AW:0];
  localparam logic [AW:0] BurstW = BURST_LEN[AW:0];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] word_cnt_q, word_cnt_d;
  logic        byte_sel_q, byte_sel_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_hi_q, rd_hi_d;     // half of the RAM read word to present

  logic          full, empty, wr_acc, rd_acc, slot_free;
  logic [AW+1:0] byte_cnt;
  logic [AW:0]   free_words;
  dq_word_t      ram_rd_word;

  // Status decode from registered state only
  always_comb begin
    full       = (word_cnt_q == DepthW);
    byte_cnt   = {word_cnt_q, 1'b0} - {{(AW+1){1'b0}}, byte_sel_q};
    empty      = (byte_cnt == '0);
    free_words = DepthW - word_cnt_q;
    wr_acc     = fifo_if.fifo_wr_en & ~full;
    rd_acc     = fifo_if.fifo_rd_en & ~empty;
    // A word slot is released only once its high byte has been read
    slot_free  = rd_acc & (byte_sel_q == HI_BYTE);
  end

  // Pointer, byte-select and occupancy next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    word_cnt_d = word_cnt_q;
    byte_sel_d = byte_sel_q;
    rd_valid_d = rd_acc;
    rd_hi_d    = rd_hi_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      byte_sel_d = ~byte_sel_q;
      rd_hi_d    = byte_sel_q;
    end
    if (slot_free) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_acc && !slot_free) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end else if (!wr_acc && slot_free) begin
      word_cnt_d = word_cnt_q - 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      word_cnt_q <= '0;
      byte_sel_q <= LO_BYTE;
      rd_valid_q <= 1'b0;
      rd_hi_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      word_cnt_q <= word_cnt_d;
      byte_sel_q <= byte_sel_d;
      rd_valid_q <= rd_valid_d;
      rd_hi_q    <= rd_hi_d;
    end
  end

  // The head word is re-read for its high byte; the slot cannot be
  // overwritten meanwhile because a partially read word still counts as full.
  rfifo_ram_sync #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (SDRAM_DQ_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_acc),
    .wr_addr_i(wr_ptr_q[AW-1:0]),
    .wr_data_i(fifo_if.fifo_wr_data),
    .rd_en_i  (rd_acc),
    .rd_addr_i(rd_ptr_q[AW-1:0]),
    .rd_data_o(ram_rd_word)
  );

  // Output drive
  always_comb begin
    fifo_if.fifo_full         = full;
    fifo_if.fifo_empty        = empty;
    fifo_if.fifo_byte_cnt     = byte_cnt;
    fifo_if.rfifo_burst_ready = (free_words >= BurstW);
    fifo_if.fifo_rd_valid     = rd_valid_q;
    fifo_if.fifo_rd_data      = rd_hi_q ? ram_rd_word[15:8] : ram_rd_word[7:0];
  end

`ifdef RFIFO_ERR_FLAGS_EN
  logic wr_err_q, wr_err_d;
  logic rd_err_q, rd_err_d;

  // Sticky overflow/underflow capture; no effect on the data path
  always_comb begin
    wr_err_d = wr_err_q | (fifo_if.fifo_wr_en & full);
    rd_err_d = rd_err_q | (fifo_if.fifo_rd_en & empty);
  end

  // Error flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign fifo_if.fifo_wr_err = wr_err_q;
  assign fifo_if.fifo_rd_err = rd_err_q;
`endif

endmodule

// File: tb/tb_rfifo_sync_16to8.sv
// Directed bench for rfifo_sync_16to8: reset, byte ordering, full/burst
// boundaries, simultaneous traffic across pointer wrap, empty-read drop and
// asynchronous reset mid-stream.
module tb_rfifo_sync_16to8;

  logic clk;
  logic rst;

  rfifo_sync_16to8_if #(.AW(9)) bus ();

  rfifo_sync_16to8 #(
    .DEPTH    (512),
    .AW       (9),
    .BURST_LEN(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .fifo_if(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_miscmp;
  logic [7:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [15:0] data, input logic rd);
    bus.fifo_wr_en   = wr;
    bus.fifo_wr_data = data;
    bus.fifo_rd_en   = rd;
  endtask

  function automatic logic [15:0] word_of(input int i);
    return {8'(i * 7 + 3), 8'(i)};
  endfunction

  task automatic push_word(input logic [15:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
  endtask

  // One byte read with the popped model byte compared on the following sample
  task automatic read_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    drive(1'b0, 16'h0, 1'b1);
    tick();
    chk({tag, "_data"}, 32'(bus.fifo_rd_data), 32'(e));
    chk({tag, "_vld"}, 32'(bus.fifo_rd_valid), 32'd1);
  endtask

  task automatic check_reset_flags(input string tag);
    chk({tag, "_empty"}, 32'(bus.fifo_empty), 32'd1);
    chk({tag, "_full"}, 32'(bus.fifo_full), 32'd0);
    chk({tag, "_cnt"}, 32'(bus.fifo_byte_cnt), 32'd0);
    chk({tag, "_burst"}, 32'(bus.rfifo_burst_ready), 32'd1);
    chk({tag, "_vld"}, 32'(bus.fifo_rd_valid), 32'd0);
    chk({tag, "_data"}, 32'(bus.fifo_rd_data), 32'd0);
`ifdef RFIFO_ERR_FLAGS_EN
    chk({tag, "_wrerr"}, 32'(bus.fifo_wr_err), 32'd0);
    chk({tag, "_rderr"}, 32'(bus.fifo_rd_err), 32'd0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    rst      = 1'b1;
    drive(1'b0, 16'h0, 1'b0);
    #12;
    check_reset_flags("rst");
    tick();
    rst = 1'b0;
    tick();
    check_reset_flags("idle");

    // Two words, four bytes low-first
    drive(1'b1, 16'hA1B2, 1'b0);
    tick();
    drive(1'b1, 16'hC3D4, 1'b0);
    tick();
    chk("two_cnt", 32'(bus.fifo_byte_cnt), 32'd4);
    drive(1'b0, 16'h0, 1'b1);
    tick();
    chk("b0", 32'(bus.fifo_rd_data), 32'hB2);
    chk("b0_vld", 32'(bus.fifo_rd_valid), 32'd1);
    chk("b0_cnt", 32'(bus.fifo_byte_cnt), 32'd3);
    tick();
    chk("b1", 32'(bus.fifo_rd_data), 32'hA1);
    chk("b1_cnt", 32'(bus.fifo_byte_cnt), 32'd2);
    tick();
    chk("b2", 32'(bus.fifo_rd_data), 32'hD4);
    chk("b2_cnt", 32'(bus.fifo_byte_cnt), 32'd1);
    tick();
    chk("b3", 32'(bus.fifo_rd_data), 32'hC3);
    chk("b3_cnt", 32'(bus.fifo_byte_cnt), 32'd0);
    chk("b3_empty", 32'(bus.fifo_empty), 32'd1);
    drive(1'b0, 16'h0, 1'b0);
    tick();
    chk("hold_vld", 32'(bus.fifo_rd_valid), 32'd0);
    chk("hold_data", 32'(bus.fifo_rd_data), 32'hC3);

    // Fill to full, watching burst-space and full boundaries
    for (int k = 1; k <= 512; k++) begin
      drive(1'b1, word_of(k - 1), 1'b0);
      push_word(word_of(k - 1));
      tick();
      if (k == 504) chk("burst_504", 32'(bus.rfifo_burst_ready), 32'd1);
      if (k == 505) chk("burst_505", 32'(bus.rfifo_burst_ready), 32'd0);
      if (k == 511) chk("full_511", 32'(bus.fifo_full), 32'd0);
    end
    chk("full_512", 32'(bus.fifo_full), 32'd1);
    chk("cnt_512", 32'(bus.fifo_byte_cnt), 32'd1024);
    drive(1'b1, 16'hDEAD, 1'b0);
    tick();
    chk("ovf_full", 32'(bus.fifo_full), 32'd1);
    chk("ovf_cnt", 32'(bus.fifo_byte_cnt), 32'd1024);
`ifdef RFIFO_ERR_FLAGS_EN
    chk("ovf_wrerr", 32'(bus.fifo_wr_err), 32'd1);
`endif

    // Half-read word still occupies its slot
    read_check("full_rd0");
    chk("full_rd0_full", 32'(bus.fifo_full), 32'd1);
    chk("full_rd0_cnt", 32'(bus.fifo_byte_cnt), 32'd1023);
    read_check("full_rd1");
    chk("full_rd1_full", 32'(bus.fifo_full), 32'd0);
    chk("full_rd1_cnt", 32'(bus.fifo_byte_cnt), 32'd1022);
    drive(1'b1, 16'h1234, 1'b0);
    push_word(16'h1234);
    tick();
    chk("refill_full", 32'(bus.fifo_full), 32'd1);
    chk("refill_cnt", 32'(bus.fifo_byte_cnt), 32'd1024);

    // Drain everything in order
    for (int i = 0; i < 1024; i++) begin
      read_check("drain");
    end
    chk("drain_empty", 32'(bus.fifo_empty), 32'd1);
    chk("drain_burst", 32'(bus.rfifo_burst_ready), 32'd1);

    // Streaming: one word in every other cycle, one byte out every cycle
    drive(1'b1, word_of(999), 1'b0);
    push_word(word_of(999));
    tick();
    for (int c = 0; c < 2200; c++) begin
      logic [7:0] e;
      logic       wr;
      wr = (c % 2 == 0);
      drive(wr, word_of(1000 + c), 1'b1);
      if (wr) push_word(word_of(1000 + c));
      e = exp_q.pop_front();
      tick();
      chk("strm_data", 32'(bus.fifo_rd_data), 32'(e));
      chk("strm_cnt", 32'(bus.fifo_byte_cnt), wr ? 32'd3 : 32'd2);
    end
    read_check("strm_tail0");
    read_check("strm_tail1");
    chk("strm_empty", 32'(bus.fifo_empty), 32'd1);

    // Read at empty with a concurrent write: read is dropped
    drive(1'b1, 16'h55AA, 1'b1);
    push_word(16'h55AA);
    tick();
    chk("erd_vld", 32'(bus.fifo_rd_valid), 32'd0);
    chk("erd_cnt", 32'(bus.fifo_byte_cnt), 32'd2);
`ifdef RFIFO_ERR_FLAGS_EN
    chk("erd_rderr", 32'(bus.fifo_rd_err), 32'd1);
`endif
    read_check("erd_next");
    chk("erd_next_cnt", 32'(bus.fifo_byte_cnt), 32'd1);

    // Asynchronous reset mid-stream, asserted away from a clock edge
    drive(1'b1, 16'h7788, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_flags("arst");
    drive(1'b0, 16'h0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_reset_flags("post_arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
